// File: rtl/disp_value_formatter.sv
// Sequential 16-bit value formatter for the 8-digit 7-segment debug display.
// A double-dabble engine produces BCD; FORMAT applies digit fill, zero blanking and sign placement.
module disp_value_formatter #(
  parameter logic [4:0] BLANK_CODE = 5'd31,
  parameter logic [4:0] MINUS_CODE = 5'd16,
  parameter bit         ZERO_BLANK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] val,
  output logic        busy,
  output logic        done,
  output logic [39:0] digits
);

  // Handshake: start is a request taken only while busy=0 (IDLE); done pulses
  // for one cycle when digits change; start in the done cycle is accepted.
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  localparam logic [39:0] RESET_DIGITS = {{7{BLANK_CODE}}, 5'd0};

  state_t      state;
  logic [3:0]  count;
  logic [19:0] bcd;
  logic [15:0] bin;
  logic [1:0]  mode_q;
  logic [15:0] val_q;
  logic        neg;

  logic        start_neg;
  logic [15:0] mag;
  logic [19:0] bcd_adj;
  logic [4:0]  raw [8];
  int          shown;
  int          top;
  logic [39:0] fmt_digits;

  // 0x8000 negates to 0x8000, which read unsigned is the required 32768.
  always_comb begin
    start_neg = (mode == 2'b01) && val[15];
    mag       = start_neg ? (~val + 16'd1) : val;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) raw[i] = BLANK_CODE;
    case (mode_q)
      2'b00, 2'b01: begin
        shown = 5;
        for (int i = 0; i < 5; i++) raw[i] = {1'b0, bcd[4*i +: 4]};
      end
      2'b10: begin
        shown = 8;
        for (int i = 0; i < 8; i++) raw[i] = {4'b0000, val_q[i]};
      end
      default: begin
        shown = 4;
        for (int i = 0; i < 4; i++) raw[i] = {1'b0, val_q[4*i +: 4]};
      end
    endcase

    // top is the leftmost position that is displayed as a digit
    top = ZERO_BLANK ? 0 : shown - 1;
    if (ZERO_BLANK) begin
      for (int i = 1; i < 8; i++) begin
        if (i < shown && raw[i] != 5'd0) top = i;
      end
    end

    fmt_digits = '0;
    for (int i = 0; i < 8; i++) begin
      if (i <= top)                 fmt_digits[5*i +: 5] = raw[i];
      else if (neg && i == top + 1) fmt_digits[5*i +: 5] = MINUS_CODE;
      else                          fmt_digits[5*i +: 5] = BLANK_CODE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= 4'd0;
      bcd    <= 20'd0;
      bin    <= 16'd0;
      mode_q <= 2'b00;
      val_q  <= 16'd0;
      neg    <= 1'b0;
      digits <= RESET_DIGITS;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            val_q  <= val;
            neg    <= start_neg;
            bin    <= mag;
            bcd    <= 20'd0;
            count  <= 4'd0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          count      <= count + 4'd1;
          if (count == 4'd15) state <= FORMAT;
        end
        FORMAT: begin
          digits <= fmt_digits;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_value_formatter.sv
// Bench for disp_value_formatter: arithmetic reference model checked every cycle,
// plus directed conversions with hand-computed digit literals and latency checks.
module tb_disp_value_formatter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] val;
  logic        busy;
  logic        done;
  logic [39:0] digits;

  int n_checks = 0;
  int n_pass   = 0;

  disp_value_formatter dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .val    (val),
    .busy   (busy),
    .done   (done),
    .digits (digits)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [39:0] dg(input int d7, d6, d5, d4, d3, d2, d1, d0);
    return {5'(d7), 5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  // Reference formatting from the display rules, using plain division
  function automatic logic [39:0] model_fmt(input logic [1:0] m, input logic [15:0] v);
    int d[8];
    int n, t, mg, vi;
    bit ng;
    logic [39:0] r;
    vi = int'(v);
    ng = (m == 2'b01) && v[15];
    mg = ng ? 65536 - vi : vi;
    for (int i = 0; i < 8; i++) d[i] = 0;
    if (m == 2'b10) begin
      n = 8;
      for (int i = 0; i < 8; i++) d[i] = (vi >> i) & 1;
    end else if (m == 2'b11) begin
      n = 4;
      for (int i = 0; i < 4; i++) d[i] = (vi >> (4 * i)) & 15;
    end else begin
      n = 5;
      for (int i = 0; i < 5; i++) begin
        d[i] = mg % 10;
        mg   = mg / 10;
      end
    end
    t = 0;
    for (int i = 0; i < n; i++) if (d[i] != 0) t = i;
    for (int i = 0; i < 8; i++) begin
      if (i <= t)                r[5*i +: 5] = 5'(d[i]);
      else if (ng && i == t + 1) r[5*i +: 5] = 5'd16;
      else                       r[5*i +: 5] = 5'd31;
    end
    return r;
  endfunction

  // Cycle model: conversion accepted when idle, result 17 edges later
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [39:0] m_pend = '0;
  logic [39:0] m_digits;
  initial m_digits = dg(31, 31, 31, 31, 31, 31, 31, 0);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left   <= 0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_digits <= dg(31, 31, 31, 31, 31, 31, 31, 0);
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_digits <= m_pend;
          m_done   <= 1'b1;
          m_busy   <= 1'b0;
        end
      end else if (start) begin
        m_pend <= model_fmt(mode, val);
        m_left <= 17;
        m_busy <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Compare process: every cycle, away from the rising edge
  always @(negedge clock) begin
    chk("busy_vs_model", 64'(busy), 64'(m_busy));
    chk("done_vs_model", 64'(done), 64'(m_done));
    chk("digits_vs_model", 64'(digits), 64'(m_digits));
  end

  // driver: one conversion, checks latency, busy length and the digits
  task automatic run_conv(input logic [1:0] m, input logic [15:0] v, input logic [39:0] exp,
                          input string nm);
    int c, bc;
    @(negedge clock);
    start = 1'b1;
    mode  = m;
    val   = v;
    @(negedge clock);
    start = 1'b0;
    c  = 0;
    bc = 0;
    while (!done && c < 40) begin
      if (busy) bc++;
      @(negedge clock);
      c++;
    end
    chk({nm, "_latency"}, 64'(c), 64'd17);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'd17);
    chk({nm, "_digits"}, 64'(digits), 64'(exp));
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (!done && c < 60) begin
      @(negedge clock);
      c++;
    end
    chk({nm, "_done_seen"}, 64'(done), 64'd1);
  endtask

  // Pin the model itself with hand-computed literals
  initial begin
    chk("model_u_ffff", 64'(model_fmt(2'b00, 16'hFFFF)), 64'(dg(31, 31, 31, 6, 5, 5, 3, 5)));
    chk("model_s_8000", 64'(model_fmt(2'b01, 16'h8000)), 64'(dg(31, 31, 16, 3, 2, 7, 6, 8)));
    chk("model_h_00a0", 64'(model_fmt(2'b11, 16'h00A0)), 64'(dg(31, 31, 31, 31, 31, 31, 10, 0)));
    chk("model_b_0005", 64'(model_fmt(2'b10, 16'h0005)), 64'(dg(31, 31, 31, 31, 31, 1, 0, 1)));
  end

  initial begin
    int nd, first_k, second_k;
    reset = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    val   = 16'd0;
    repeat (3) @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_digits", 64'(digits), 64'(dg(31, 31, 31, 31, 31, 31, 31, 0)));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_conv(2'b00, 16'hFFFF, dg(31, 31, 31, 6, 5, 5, 3, 5), "u_ffff");
    run_conv(2'b01, 16'hFFFF, dg(31, 31, 31, 31, 31, 31, 16, 1), "s_ffff");
    run_conv(2'b01, 16'h8000, dg(31, 31, 16, 3, 2, 7, 6, 8), "s_8000");
    run_conv(2'b10, 16'h0005, dg(31, 31, 31, 31, 31, 1, 0, 1), "b_0005");
    run_conv(2'b10, 16'h00FF, dg(1, 1, 1, 1, 1, 1, 1, 1), "b_00ff");
    run_conv(2'b10, 16'h0000, dg(31, 31, 31, 31, 31, 31, 31, 0), "b_0000");
    run_conv(2'b11, 16'h00A0, dg(31, 31, 31, 31, 31, 31, 10, 0), "h_00a0");
    run_conv(2'b11, 16'h1234, dg(31, 31, 31, 31, 1, 2, 3, 4), "h_1234");
    run_conv(2'b01, 16'd42, dg(31, 31, 31, 31, 31, 31, 4, 2), "s_pos42");
    repeat (3) @(negedge clock);
    chk("digits_hold", 64'(digits), 64'(dg(31, 31, 31, 31, 31, 31, 4, 2)));

    // start held high for 40 cycles: back-to-back accepts, none while busy
    @(negedge clock);
    start = 1'b1;
    mode  = 2'b00;
    val   = 16'd100;
    nd = 0;
    first_k = -1;
    second_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(nd), 64'd2);
    chk("held_first_done", 64'(first_k), 64'd17);
    chk("held_second_done", 64'(second_k), 64'd35);
    chk("held_digits", 64'(digits), 64'(dg(31, 31, 31, 31, 31, 1, 0, 0)));
    wait_done("held_third");
    repeat (2) @(negedge clock);

    // start pulse during SHIFT is ignored
    @(negedge clock);
    start = 1'b1;
    mode  = 2'b11;
    val   = 16'hBEEF;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1;
    val   = 16'h0001;
    @(negedge clock);
    start = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("midshift_done_count", 64'(nd), 64'd1);
    chk("midshift_digits", 64'(digits), 64'(dg(31, 31, 31, 31, 11, 14, 14, 15)));

    // reset asserted at SHIFT count 7
    @(negedge clock);
    start = 1'b1;
    mode  = 2'b00;
    val   = 16'd999;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_digits", 64'(digits), 64'(dg(31, 31, 31, 31, 31, 31, 31, 0)));
    @(negedge clock);
    reset = 1'b1;
    run_conv(2'b00, 16'd1234, dg(31, 31, 31, 31, 1, 2, 3, 4), "after_reset");

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
